// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, LSB first, with a full 2*W product.
// Signed operands are supported only when SHIFT_ADD_MULTIPLIER_SIGNED_EN is defined; otherwise tc is ignored.
module shift_add_multiplier #(
    parameter int W  = 65,
    parameter int PW = 2 * W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          tc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] product,
    output logic [1:0]    o_dbg_state
);

    // Handshake: operands transfer on a rising edge with in_valid && in_ready.
    // The product transfers on a rising edge with out_valid && out_ready.
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_mcand;
    logic [PW-1:0] r_product;
    logic [PW-1:0] w_acc_nxt;
    logic [W-1:0]  r_mplier;
    logic [CW-1:0] r_cnt;
    logic          r_tc;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          w_in_ready_nxt;
    logic          w_out_valid_nxt;
    logic          w_accept;
    logic          w_last_bit;
    logic          w_bits_done;
    logic          w_tc_in;

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    assign w_tc_in = tc;
`else
    assign w_tc_in = tc & 1'b0;
`endif

    assign w_accept    = (r_state == S_IDLE) && in_valid;
    assign w_last_bit  = (r_cnt == CW'(W - 1));
    assign w_bits_done = (r_cnt == CW'(W));

    // The multiplier MSB carries weight -2^(W-1) in two's complement, so it subtracts.
    always_comb begin
        w_acc_nxt = r_acc;
        if (r_mplier[0]) begin
            if (w_last_bit && r_tc) begin
                w_acc_nxt = r_acc - r_mcand;
            end else begin
                w_acc_nxt = r_acc + r_mcand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)    w_state_nxt = S_RUN;
            S_RUN:   if (w_bits_done) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // W bit steps run while r_cnt < W; the edge that sees r_cnt == W publishes the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_tc     <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= {{W{a[W-1] & w_tc_in}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
            r_tc     <= w_tc_in;
        end else if ((r_state == S_RUN) && !w_bits_done) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if ((r_state == S_RUN) && w_bits_done) begin
            r_product <= r_acc;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign product     = r_product;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at W=65; expectations follow SHIFT_ADD_MULTIPLIER_SIGNED_EN.
module tb_shift_add_multiplier;

    localparam int W  = 65;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          tc;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] exp_allones;
    logic [PW-1:0] exp_m1;
    logic [PW-1:0] exp_m3x5;
    logic [W-1:0]  all_ones;
    logic [W-1:0]  most_neg;
    logic [W-1:0]  minus3;

    shift_add_multiplier #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .tc         (tc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge, then scramble them to show they are not re-sampled.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ttc);
        @(negedge clk);
        a = ta; b = tb_v; tc = ttc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a  = W'({$urandom(), $urandom(), $urandom()});
        b  = W'({$urandom(), $urandom(), $urandom()});
        tc = ~ttc;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < W + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        check({tag, "_lat"}, PW'(n), PW'(W + 1));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_consumed"}, PW'(out_valid), PW'(0));
    endtask

    task automatic mult(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ttc,
                        input logic [PW-1:0] exp, input string tag);
        send(ta, tb_v, ttc);
        wait_done(tag);
        check({tag, "_prod"}, product, exp);
        consume(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; tc = 1'b0;
        all_ones    = '1;
        most_neg    = W'(1) << (W - 1);
        minus3      = W'(0) - W'(3);
        exp_allones = PW'(0) - (PW'(1) << (W + 1)) + PW'(1);
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
        exp_m1   = PW'(1);
        exp_m3x5 = PW'(0) - PW'(15);
`else
        exp_m1   = exp_allones;
        exp_m3x5 = (PW'(5) << W) - PW'(15);
`endif

        #12;
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_in_ready", PW'(in_ready), PW'(1));
        check("rst_product", product, PW'(0));
        check("rst_state", PW'(dbg_state), PW'(0));

        // Operands are presented on the very first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        a = W'(1); b = W'(1); tc = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = '1; b = '1;
        wait_done("one_x_one");
        check("one_x_one_prod", product, PW'(1));
        consume("one_x_one");

        for (int i = 0; i < W; i++) begin
            int j;
            j = (i * 7 + 3) % W;
            mult(W'(1) << i, W'(1) << j, 1'b0, PW'(1) << (i + j), $sformatf("walk_%0d_%0d", i, j));
        end
        for (int j = 0; j < W; j++) begin
            mult(W'(1) << (W - 1 - j), W'(1) << j, 1'b0, PW'(1) << (W - 1), $sformatf("walk_rev_%0d", j));
        end

        mult(all_ones, all_ones, 1'b0, exp_allones, "allones_u");
        mult(all_ones, all_ones, 1'b1, exp_m1, "minus1_sq");
        mult(most_neg, most_neg, 1'b1, PW'(1) << (2 * W - 2), "mostneg_sq");
        mult(minus3, W'(5), 1'b1, exp_m3x5, "m3_x_5");
        mult(W'(0), all_ones, 1'b1, PW'(0), "zero_x_ones");
        mult(W'(12345), W'(678), 1'b0, PW'(8369910), "mid_u");

        // Hold the product in DONE while in_valid is asserted with other operands.
        send(W'(5), W'(9), 1'b0);
        wait_done("hold");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = W'($urandom()); b = W'($urandom());
            @(posedge clk);
            #1;
            check($sformatf("hold_valid_%0d", k), PW'(out_valid), PW'(1));
            check($sformatf("hold_prod_%0d", k), product, PW'(45));
            check($sformatf("hold_in_ready_%0d", k), PW'(in_ready), PW'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("hold_release_valid", PW'(out_valid), PW'(0));
        check("hold_release_ready", PW'(in_ready), PW'(1));
        check("hold_release_state", PW'(dbg_state), PW'(0));
        check("hold_prod_kept", product, PW'(45));
        @(posedge clk);
        #1;
        check("no_accept_on_consume", PW'(in_ready), PW'(1));

        // Reset in the middle of RUN discards the work in flight.
        send(all_ones, W'(3), 1'b0);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", PW'(out_valid), PW'(0));
        check("mid_rst_prod", product, PW'(0));
        check("mid_rst_state", PW'(dbg_state), PW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        mult(W'(7), W'(6), 1'b0, PW'(42), "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
